// File: rtl/demux_reg.sv
// ----------------------------------------------------------------------------
// demux_reg
//
// Registered 1-to-N demultiplexer. A word and a destination index are taken
// in over a valid/ready handshake, held in a one-entry register and then
// presented on exactly one of N_OUT destination ports. Each destination port
// has its own valid/ready pair. Out-of-range indices are accepted, dropped and
// reported on ERR with a one-cycle pulse.
//
// Ports
//   CLK      in   1              clock, all state on rising edge
//   RST      in   1              synchronous, active-high reset
//   A        in   DATA_W         input data word
//   S        in   SEL_W          destination index
//   A_VALID  in   1              input word valid
//   A_READY  out  1              block can accept a word this cycle
//   X        out  N_OUT*DATA_W   packed outputs, port k = X[k*DATA_W +: DATA_W]
//   X_VALID  out  N_OUT          per-port valid, one-hot or zero
//   X_READY  in   N_OUT          per-port ready from destination
//   ERR      out  1              one-cycle pulse: out-of-range S dropped
//
// Configuration macro: DEMUX_ZERO_IDLE_EN
//   defined   : ports without valid drive all-zero data
//   undefined : each port keeps the last word delivered to it until
//               overwritten or reset
// ----------------------------------------------------------------------------
module demux_reg #(
    parameter int DATA_W = 32,
    parameter int N_OUT  = 2,
    parameter int SEL_W  = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_W-1:0]       A,
    input  logic [SEL_W-1:0]        S,
    input  logic                    A_VALID,
    output logic                    A_READY,
    output logic [N_OUT*DATA_W-1:0] X,
    output logic [N_OUT-1:0]        X_VALID,
    input  logic [N_OUT-1:0]        X_READY,
    output logic                    ERR
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Port count widened by one bit so the range compare works even when
    // 2**SEL_W == N_OUT.
    localparam logic [SEL_W:0] N_OUT_W = (SEL_W + 1)'(N_OUT);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] data_q;
    logic [SEL_W-1:0]  sel_q;
    logic              err_q;
    logic              sel_ready;
    logic              in_range;
    logic              accept;
    logic              load;
    logic              fire;

`ifndef DEMUX_ZERO_IDLE_EN
    logic [N_OUT*DATA_W-1:0] last_q;
`endif

    // Ready of the currently selected destination; ready bits of the other
    // ports are deliberately ignored.
    always_comb begin
        sel_ready = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (sel_q == SEL_W'(k)) begin
                sel_ready = X_READY[k];
            end
        end
    end

    // Handshake qualifiers. An accept with an out-of-range index still
    // completes the input handshake but never loads the holding register.
    always_comb begin
        in_range = ({1'b0, S} < N_OUT_W);
        accept   = A_VALID & A_READY;
        load     = accept & in_range;
        fire     = (state_q == FULL) & sel_ready;
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A fire together with a valid accept keeps the block
    // FULL so a stream can run at one word per cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (load) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (fire) begin
                    state_d = load ? FULL : EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Holding register, error pulse and per-port last-word registers.
    // A held word only changes on load, which in FULL requires a fire, so
    // data stays stable while the selected destination stalls.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_q <= '0;
            sel_q  <= '0;
            err_q  <= 1'b0;
`ifndef DEMUX_ZERO_IDLE_EN
            last_q <= '0;
`endif
        end else begin
            err_q <= accept & ~in_range;
            if (load) begin
                data_q <= A;
                sel_q  <= S;
            end
`ifndef DEMUX_ZERO_IDLE_EN
            if (fire) begin
                for (int k = 0; k < N_OUT; k++) begin
                    if (sel_q == SEL_W'(k)) begin
                        last_q[k*DATA_W +: DATA_W] <= data_q;
                    end
                end
            end
`endif
        end
    end

    // Outputs. The selected port shows the held word while FULL; every other
    // port shows either zero or its last delivered word.
    always_comb begin
        X       = '0;
        X_VALID = '0;
        A_READY = (state_q == EMPTY) | ((state_q == FULL) & sel_ready);
        ERR     = err_q;
        for (int k = 0; k < N_OUT; k++) begin
            if ((state_q == FULL) && (sel_q == SEL_W'(k))) begin
                X_VALID[k]                = 1'b1;
                X[k*DATA_W +: DATA_W]     = data_q;
            end else begin
`ifdef DEMUX_ZERO_IDLE_EN
                X[k*DATA_W +: DATA_W]     = '0;
`else
                X[k*DATA_W +: DATA_W]     = last_q[k*DATA_W +: DATA_W];
`endif
            end
        end
    end

endmodule

// File: tb/tb_demux_reg.sv
// ----------------------------------------------------------------------------
// tb_demux_reg
//
// Self-checking bench for demux_reg. A two-port instance is driven by a
// vector table and hand-written sequences, with a queue-based scoreboard
// watching every cycle. A three-port instance exercises out-of-range indices.
// ----------------------------------------------------------------------------
module tb_demux_reg;

    localparam int DATA_W = 32;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] A;
    logic        S;
    logic        A_VALID;
    logic        A_READY;
    logic [63:0] X;
    logic [1:0]  X_VALID;
    logic [1:0]  X_READY;
    logic        ERR;

    logic        rst3;
    logic [31:0] a3;
    logic [1:0]  s3;
    logic        av3;
    logic        ar3;
    logic [95:0] x3;
    logic [2:0]  xv3;
    logic [2:0]  xr3;
    logic        err3;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b1;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } sb_item_t;

    sb_item_t    sb_q[$];
    logic [31:0] m_last[2];

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic        s;
        logic [1:0]  xr;
        logic [1:0]  exp_xv;
        logic [31:0] exp_x0;
        logic [31:0] exp_x1;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[11];

    demux_reg #(.DATA_W(32), .N_OUT(2), .SEL_W(1)) dut (
        .CLK(CLK), .RST(RST), .A(A), .S(S), .A_VALID(A_VALID),
        .A_READY(A_READY), .X(X), .X_VALID(X_VALID), .X_READY(X_READY),
        .ERR(ERR)
    );

    demux_reg #(.DATA_W(32), .N_OUT(3), .SEL_W(2)) dut3 (
        .CLK(CLK), .RST(rst3), .A(a3), .S(s3), .A_VALID(av3),
        .A_READY(ar3), .X(x3), .X_VALID(xv3), .X_READY(xr3),
        .ERR(err3)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then step to just after the next edge.
    task automatic apply_stimulus(input logic rst, input logic v,
                                  input logic [31:0] a, input logic s,
                                  input logic [1:0] xr);
        RST     = rst;
        A_VALID = v;
        A       = a;
        S       = s;
        X_READY = xr;
        @(posedge CLK);
        #1;
    endtask

    // Idle-port expectation depends on the build option.
    function automatic logic [31:0] idle_val(input logic [31:0] last);
`ifdef DEMUX_ZERO_IDLE_EN
        return 32'h0;
`else
        return last;
`endif
    endfunction

    // Scoreboard monitor on the two-port instance. Sampled at the falling
    // edge, when this cycle's inputs are settled; the queue front is the word
    // the DUT must currently be holding.
    initial begin : monitor
        logic        exp_ready;
        logic        full;
        logic        sel;
        logic [31:0] exp_x;
        sb_item_t    item;
        m_last[0] = '0;
        m_last[1] = '0;
        @(posedge CLK);
        while (mon_en) begin
            @(negedge CLK);
            if (!mon_en) break;
            full      = (sb_q.size() != 0);
            sel       = full ? sb_q[0].port : 1'b0;
            exp_ready = !full || X_READY[sel];
            check_output("mon_a_ready", A_READY, exp_ready);
            check_output("mon_x_valid", X_VALID, full ? (2'b01 << sel) : 2'b00);
            check_output("mon_err", ERR, 1'b0);
            for (int k = 0; k < 2; k++) begin
                exp_x = (full && sel == k[0]) ? sb_q[0].data : idle_val(m_last[k]);
                check_output($sformatf("mon_x%0d", k), X[k*32 +: 32], exp_x);
            end
            if (RST) begin
                sb_q.delete();
                m_last[0] = '0;
                m_last[1] = '0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (X_VALID[k] && X_READY[k]) begin
                        if (sb_q.size() == 0) begin
                            check_output("sb_pop_empty", 1'b1, 1'b0);
                        end else begin
                            item = sb_q.pop_front();
                            check_output("sb_port", k[0], item.port);
                            check_output("sb_data", X[k*32 +: 32], item.data);
                            m_last[k] = item.data;
                        end
                    end
                end
                if (A_VALID && exp_ready) begin
                    sb_q.push_back('{port: S, data: A});
                end
            end
        end
    end

    initial begin : stim
        vecs[0]  = '{1'b1, 32'h0000FFFF, 1'b1, 2'b11, 2'b10, 32'h0, 32'h0000FFFF, 1'b1};
        vecs[1]  = '{1'b0, 32'h0,        1'b0, 2'b11, 2'b00, 32'h0, 32'h0000FFFF, 1'b1};
        vecs[2]  = '{1'b1, 32'h1, 1'b0, 2'b11, 2'b01, 32'h1, 32'h0000FFFF, 1'b1};
        vecs[3]  = '{1'b1, 32'h2, 1'b1, 2'b11, 2'b10, 32'h1, 32'h2, 1'b1};
        vecs[4]  = '{1'b1, 32'h3, 1'b0, 2'b11, 2'b01, 32'h3, 32'h2, 1'b1};
        vecs[5]  = '{1'b1, 32'h4, 1'b1, 2'b11, 2'b10, 32'h3, 32'h4, 1'b1};
        vecs[6]  = '{1'b1, 32'h5, 1'b0, 2'b11, 2'b01, 32'h5, 32'h4, 1'b1};
        vecs[7]  = '{1'b1, 32'h6, 1'b1, 2'b11, 2'b10, 32'h5, 32'h6, 1'b1};
        vecs[8]  = '{1'b1, 32'h7, 1'b0, 2'b11, 2'b01, 32'h7, 32'h6, 1'b1};
        vecs[9]  = '{1'b1, 32'h8, 1'b1, 2'b11, 2'b10, 32'h7, 32'h8, 1'b1};
        vecs[10] = '{1'b0, 32'h0, 1'b0, 2'b11, 2'b00, 32'h7, 32'h8, 1'b1};

        RST = 1'b1; A_VALID = 1'b1; A = 32'hA5A5A5A5; S = 1'b0; X_READY = 2'b00;
        rst3 = 1'b1; av3 = 1'b0; a3 = '0; s3 = '0; xr3 = 3'b000;

        // Reset held two cycles with a pending word: nothing is accepted.
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 2'b00);
            check_output("t1_x", X, 64'h0);
            check_output("t1_x_valid", X_VALID, 2'b00);
            check_output("t1_err", ERR, 1'b0);
        end
        RST = 1'b0; A_VALID = 1'b0; X_READY = 2'b11;
        #1;
        check_output("t1_a_ready", A_READY, 1'b1);

        // Single transfer then an alternating back-to-back stream.
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(1'b0, vecs[i].v, vecs[i].a, vecs[i].s, vecs[i].xr);
            check_output($sformatf("vec%0d_x_valid", i), X_VALID, vecs[i].exp_xv);
            check_output($sformatf("vec%0d_x0", i), X[31:0],
                         vecs[i].exp_xv[0] ? vecs[i].exp_x0 : idle_val(vecs[i].exp_x0));
            check_output($sformatf("vec%0d_x1", i), X[63:32],
                         vecs[i].exp_xv[1] ? vecs[i].exp_x1 : idle_val(vecs[i].exp_x1));
            check_output($sformatf("vec%0d_a_ready", i), A_READY, vecs[i].exp_ready);
            check_output($sformatf("vec%0d_err", i), ERR, 1'b0);
        end

        // Backpressure: port 0 stalls while a second word waits.
        apply_stimulus(1'b0, 1'b1, 32'h12874321, 1'b0, 2'b00);
        check_output("t3_first_valid", X_VALID, 2'b01);
        check_output("t3_first_x0", X[31:0], 32'h12874321);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 1'b1, 32'h52001543, 1'b1, 2'b00);
            check_output($sformatf("t3_hold%0d_valid", i), X_VALID, 2'b01);
            check_output($sformatf("t3_hold%0d_x0", i), X[31:0], 32'h12874321);
            check_output($sformatf("t3_hold%0d_ready", i), A_READY, 1'b0);
        end
        X_READY = 2'b01;
        #1;
        check_output("t3_ready_raise", A_READY, 1'b1);
        @(posedge CLK);
        #1;
        check_output("t3_second_valid", X_VALID, 2'b10);
        check_output("t3_second_x1", X[63:32], 32'h52001543);
        check_output("t3_idle_x0", X[31:0], idle_val(32'h12874321));
        check_output("t3_ignore_nonsel", A_READY, 1'b0);

        // Reset while FULL and stalled discards the word and clears outputs.
        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 2'b00);
        check_output("t6_x_valid", X_VALID, 2'b00);
        check_output("t6_x", X, 64'h0);
        check_output("t6_err", ERR, 1'b0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 2'b00);
        check_output("t6_post_valid", X_VALID, 2'b00);
        check_output("t6_post_ready", A_READY, 1'b1);

        // Three-port instance: out-of-range index, in EMPTY and in FULL.
        rst3 = 1'b1;
        @(posedge CLK); #1;
        rst3 = 1'b0;
        check_output("t5_rst_valid", xv3, 3'b000);
        check_output("t5_rst_err", err3, 1'b0);
        av3 = 1'b1; s3 = 2'd3; a3 = 32'hDEADBEEF; xr3 = 3'b111;
        @(posedge CLK); #1;
        check_output("t5_drop_err", err3, 1'b1);
        check_output("t5_drop_valid", xv3, 3'b000);
        check_output("t5_drop_ready", ar3, 1'b1);
        s3 = 2'd2; a3 = 32'hCAFE0002;
        @(posedge CLK); #1;
        check_output("t5_load_err", err3, 1'b0);
        check_output("t5_load_valid", xv3, 3'b100);
        check_output("t5_load_x2", x3[95:64], 32'hCAFE0002);
        s3 = 2'd3; a3 = 32'hDEADBEEF;
        @(posedge CLK); #1;
        check_output("t5_fire_drop_err", err3, 1'b1);
        check_output("t5_fire_drop_valid", xv3, 3'b000);
        av3 = 1'b0;
        @(posedge CLK); #1;
        check_output("t5_err_clear", err3, 1'b0);
        check_output("t5_idle_valid", xv3, 3'b000);
        check_output("t5_idle_x2", x3[95:64], idle_val(32'hCAFE0002));

        mon_en = 1'b0;
        @(negedge CLK);
        check_output("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
